mult_share_ctrl: RTL and testbench

- Round-robin controller that shares one combinational W x W multiplier (instantiated beside it, driven through the mult_* ports) between two requesters.
- Each request is a valid/ready handshake.
- Operands are registered, the product is captured one cycle later, and it is returned on a single response channel tagged with the requester id.
- Sits between operand sources and the existing 4x4 multiplier datapath.

---
 rtl/mult_share_ctrl.sv | 144 ++++++++++++++
 tb/tb_mult_share_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter that time-shares one external combinational W x W multiplier
// between two valid/ready requesters and returns id-tagged products on one response channel.
`timescale 1ns/1ps

module mult_share_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,

  output logic [W-1:0]     mult_a,
  output logic [W-1:0]     mult_b,
  input  logic [2*W-1:0]   mult_p,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*W-1:0]   rsp_p,
  output logic             rsp_id,

  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // state | meaning
  // IDLE  | arbitrating; at most one requester sees ready
  // MULT  | operands registered, shared multiplier settling
  // HOLD  | product registered, waiting for rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     r_mult_a;
  logic [W-1:0]     r_mult_b;
  logic [2*W-1:0]   r_rsp_p;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_op_count;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_accept;
  logic             w_rsp_hs;

  // On contention the requester that was not served last wins.
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy0 = w_grant0;
        w_rdy1 = w_grant1;
        if (w_grant0 || w_grant1) begin
          w_state_nxt = MULT;
        end
      end
      MULT: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        w_rsp_hs = r_rsp_valid & rsp_ready;
        if (w_rsp_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = (w_rdy0 & req0_valid) | (w_rdy1 & req1_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mult_a     <= '0;
      r_mult_b     <= '0;
      r_rsp_p      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_mult_a     <= w_rdy1 ? req1_a : req0_a;
        r_mult_b     <= w_rdy1 ? req1_b : req0_b;
        r_rsp_id     <= w_rdy1;
        r_last_grant <= w_rdy1;
      end
      if (r_state == MULT) begin
        r_rsp_p     <= mult_p;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + CNT_W'(1);
      end
    end
  end

  // Readies are gated by rst_n so nothing is offered while reset is held.
  assign req0_ready = w_rdy0 & rst_n;
  assign req1_ready = w_rdy1 & rst_n;

  assign mult_a    = r_mult_a;
  assign mult_b    = r_mult_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: reset, contention, mid-op reset, backpressure, singles, wrap.
`timescale 1ns/1ps

module tb_mult_share_ctrl;

  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_a;
  logic [W-1:0]     req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_a;
  logic [W-1:0]     req1_b;
  logic [W-1:0]     mult_a;
  logic [W-1:0]     mult_b;
  logic [2*W-1:0]   mult_p;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_p;
  logic             rsp_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  mult_share_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_p      (rsp_p),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  // The shared multiplier lives beside the controller.
  assign mult_p = (2*W)'(mult_a) * (2*W)'(mult_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with IDLE state; ends #1 after the negedge following the handshake.
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] exp_p;
    exp_p = (2*W)'(a) * (2*W)'(b);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk("op_ready", {req1_ready, req0_ready}, id ? 2 : 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("op_busy_mult", busy, 1);
    chk("op_mult_a", mult_a, a);
    chk("op_mult_b", mult_b, b);
    chk("op_rsp_valid_early", rsp_valid, 0);
    @(negedge clk);
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp_p", rsp_p, exp_p);
    chk("op_rsp_id", rsp_id, id);
    @(negedge clk);
    #1;
    exp_cnt++;
    chk("op_rsp_valid_done", rsp_valid, 0);
    chk("op_busy_done", busy, 0);
    chk("op_count", op_count, 32'(exp_cnt % 256));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
    req1_valid = 1'b1; req1_a = 4'd2;  req1_b = 4'd6;
    rsp_ready = 1'b1;

    // Reset held with both requesters valid.
    #3;
    chk("reset_ready", {req1_ready, req0_ready}, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_mult_a", mult_a, 0);
    chk("reset_mult_b", mult_b, 0);
    chk("reset_rsp_p", rsp_p, 0);
    chk("reset_rsp_id", rsp_id, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hold_ready", {req1_ready, req0_ready}, 0);
    rst_n = 1'b1;
    #1;

    // Contention: grants alternate 0,1,0,1 starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      chk("cont_ready", {req1_ready, req0_ready}, (i % 2) ? 2 : 1);
      @(posedge clk);
      @(negedge clk);
      chk("cont_busy", busy, 1);
      chk("cont_ready_mult", {req1_ready, req0_ready}, 0);
      @(negedge clk);
      chk("cont_rsp_valid", rsp_valid, 1);
      chk("cont_rsp_p", rsp_p, (i % 2) ? 12 : 225);
      chk("cont_rsp_id", rsp_id, i % 2);
      chk("cont_ready_hold", {req1_ready, req0_ready}, 0);
      @(negedge clk);
      #1;
      exp_cnt++;
      chk("cont_rsp_done", rsp_valid, 0);
    end
    chk("cont_op_count", op_count, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset during MULT discards the operation.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd8; req0_b = 4'd8;
    #1;
    chk("midrst_ready", {req1_ready, req0_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("midrst_busy_mult", busy, 1);
    chk("midrst_mult_a", mult_a, 8);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mult_a_clr", mult_a, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_rsp_valid_hold", rsp_valid, 0);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    do_op(1'b1, 4'd5, 4'd7);
    chk("midrst_next_count", op_count, 1);

    // Backpressure: result 35 held while rsp_ready is low, req1 kept waiting.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd7;
    #1;
    chk("bp_ready", {req1_ready, req0_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd6;
    @(negedge clk);
    chk("bp_rsp_valid", rsp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_p", rsp_p, 35);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_busy", busy, 1);
      chk("bp_hold_ready", {req1_ready, req0_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_cnt++;
    chk("bp_done_valid", rsp_valid, 0);
    chk("bp_done_busy", busy, 0);
    chk("bp_done_count", op_count, 2);
    chk("bp_done_ready", {req1_ready, req0_ready}, 2);
    req1_valid = 1'b0;

    // Single requests through requester 0.
    do_reset();
    do_op(1'b0, 4'd3, 4'd1);
    do_op(1'b0, 4'd8, 4'd8);
    do_op(1'b0, 4'd5, 4'd7);
    do_op(1'b0, 4'd3, 4'd5);
    chk("single_op_count", op_count, 4);

    // Counter wrap after 256 completions.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      do_op(i[0], 4'(i), 4'(i * 7));
    end
    chk("wrap_255", op_count, 255);
    do_op(1'b1, 4'd15, 4'd15);
    chk("wrap_0", op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
